tpg_timing_ctrl: RTL and testbench

TPG_TIMING_CTRL -- requirements
Module: tpg_timing_ctrl

---
 rtl/tpg_pkg.sv | 29 ++
 rtl/tpg_timing_ctrl_if.sv | 11 +
 rtl/tpg_cfg_check.sv | 32 +++
 rtl/tpg_timing_ctrl.sv | 168 ++++++++++++++++
 tb/tb_tpg_timing_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpg_pkg.sv
// Shared constants for the test-pattern timing controller.
// Covers the config address map, timing-set slot indices and FSM states.
package tpg_pkg;

    localparam logic [3:0] ADDR_HS_START   = 4'd0;
    localparam logic [3:0] ADDR_HS_END     = 4'd1;
    localparam logic [3:0] ADDR_HACT_START = 4'd2;
    localparam logic [3:0] ADDR_HACT_END   = 4'd3;
    localparam logic [3:0] ADDR_H_END      = 4'd4;
    localparam logic [3:0] ADDR_VS_START   = 4'd5;
    localparam logic [3:0] ADDR_VS_END     = 4'd6;
    localparam logic [3:0] ADDR_VACT_START = 4'd7;
    localparam logic [3:0] ADDR_VACT_END   = 4'd8;
    localparam logic [3:0] ADDR_V_END      = 4'd9;

    // Slot order inside a horizontal or vertical timing set.
    localparam int IDX_SYNC_START = 0;
    localparam int IDX_SYNC_END   = 1;
    localparam int IDX_ACT_START  = 2;
    localparam int IDX_ACT_END    = 3;
    localparam int IDX_END        = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/tpg_timing_ctrl_if.sv
// Configuration write bus of the timing controller.
// The master side writes staging registers and pulses commit.
interface tpg_timing_ctrl_if;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_commit;

    modport master (output cfg_we, output cfg_addr, output cfg_wdata, output cfg_commit);
    modport slave  (input  cfg_we, input  cfg_addr, input  cfg_wdata, input  cfg_commit);
endinterface

// File: rtl/tpg_cfg_check.sv
// Combinational sanity check of a staged timing set.
// Windows must be non-empty and must end inside the line or frame.
module tpg_cfg_check
    import tpg_pkg::*;
#(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic [4:0][H_BITS-1:0] h_set,
    input  logic [4:0][V_BITS-1:0] v_set,
    output logic                   ok
);

    logic h_ok;
    logic v_ok;

    always_comb begin
        h_ok = (h_set[IDX_SYNC_START] < h_set[IDX_SYNC_END])
            && (h_set[IDX_SYNC_END]   <= h_set[IDX_END])
            && (h_set[IDX_ACT_START]  < h_set[IDX_ACT_END])
            && (h_set[IDX_ACT_END]    <= h_set[IDX_END])
            && (h_set[IDX_END] != '0);
        v_ok = (v_set[IDX_SYNC_START] < v_set[IDX_SYNC_END])
            && (v_set[IDX_SYNC_END]   <= v_set[IDX_END])
            && (v_set[IDX_ACT_START]  < v_set[IDX_ACT_END])
            && (v_set[IDX_ACT_END]    <= v_set[IDX_END])
            && (v_set[IDX_END] != '0);
    end

    assign ok = h_ok && v_ok;

endmodule

// File: rtl/tpg_timing_ctrl.sv
// Raster timing controller: staged/pending/active timing sets, run FSM,
// pixel counters and registered sync/enable strobes aligned with the counters.
module tpg_timing_ctrl
    import tpg_pkg::*;
#(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    tpg_timing_ctrl_if.slave  cfg,
    input  logic              start,
    input  logic              stop,
    output logic [H_BITS-1:0] tHS_START,
    output logic [H_BITS-1:0] tHS_END,
    output logic [H_BITS-1:0] tHACT_START,
    output logic [H_BITS-1:0] tHACT_END,
    output logic [H_BITS-1:0] tH_END,
    output logic [V_BITS-1:0] tVS_START,
    output logic [V_BITS-1:0] tVS_END,
    output logic [V_BITS-1:0] tVACT_START,
    output logic [V_BITS-1:0] tVACT_END,
    output logic [V_BITS-1:0] tV_END,
    output logic [H_BITS-1:0] h_cnt,
    output logic [V_BITS-1:0] v_cnt,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic              sof,
    output logic              busy,
    output logic              pend,
    output logic              cfg_err
);

    logic [4:0][H_BITS-1:0] stg_h, pnd_h, act_h, act_h_nxt;
    logic [4:0][V_BITS-1:0] stg_v, pnd_v, act_v, act_v_nxt;
    logic [H_BITS-1:0]      wdata_h, h_nxt;
    logic [V_BITS-1:0]      wdata_v, v_nxt;
    logic                   applied, cfg_ok, wrap, apply, run_nxt;
    logic                   hs_nxt, vs_nxt, hact_nxt, vact_nxt, unused_wdata;
    state_t                 state, state_nxt;

    assign wdata_h      = cfg.cfg_wdata[H_BITS-1:0];
    assign wdata_v      = cfg.cfg_wdata[V_BITS-1:0];
    assign unused_wdata = ^cfg.cfg_wdata;

    tpg_cfg_check #(.H_BITS(H_BITS), .V_BITS(V_BITS)) u_cfg_check (
        .h_set (stg_h),
        .v_set (stg_v),
        .ok    (cfg_ok)
    );

    // Pending set moves to active while idle, or on the last pixel of a frame.
    assign wrap  = (state != ST_IDLE) && (h_cnt == act_h[IDX_END]) && (v_cnt == act_v[IDX_END]);
    assign apply = pend && ((state == ST_IDLE) || wrap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_h   <= '0;
            stg_v   <= '0;
            pnd_h   <= '0;
            pnd_v   <= '0;
            act_h   <= '0;
            act_v   <= '0;
            pend    <= 1'b0;
            cfg_err <= 1'b0;
            applied <= 1'b0;
        end else begin
            if (cfg.cfg_we) begin
                case (cfg.cfg_addr)
                    ADDR_HS_START:   stg_h[IDX_SYNC_START] <= wdata_h;
                    ADDR_HS_END:     stg_h[IDX_SYNC_END]   <= wdata_h;
                    ADDR_HACT_START: stg_h[IDX_ACT_START]  <= wdata_h;
                    ADDR_HACT_END:   stg_h[IDX_ACT_END]    <= wdata_h;
                    ADDR_H_END:      stg_h[IDX_END]        <= wdata_h;
                    ADDR_VS_START:   stg_v[IDX_SYNC_START] <= wdata_v;
                    ADDR_VS_END:     stg_v[IDX_SYNC_END]   <= wdata_v;
                    ADDR_VACT_START: stg_v[IDX_ACT_START]  <= wdata_v;
                    ADDR_VACT_END:   stg_v[IDX_ACT_END]    <= wdata_v;
                    ADDR_V_END:      stg_v[IDX_END]        <= wdata_v;
                    default: ;
                endcase
            end
            if (apply) begin
                act_h   <= pnd_h;
                act_v   <= pnd_v;
                applied <= 1'b1;
                pend    <= 1'b0;
            end
            // A commit landing on the apply cycle re-arms pend for the next wrap.
            if (cfg.cfg_commit) begin
                if (cfg_ok) begin
                    pnd_h   <= stg_h;
                    pnd_v   <= stg_v;
                    pend    <= 1'b1;
                    cfg_err <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start && !stop && applied) state_nxt = ST_RUN;
            ST_RUN:      if (stop) state_nxt = ST_STOPPING;
            ST_STOPPING: if (start && !stop) state_nxt = ST_RUN;
                         else if (wrap) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        act_h_nxt = apply ? pnd_h : act_h;
        act_v_nxt = apply ? pnd_v : act_v;
        run_nxt   = (state_nxt != ST_IDLE);
        h_nxt     = '0;
        v_nxt     = '0;
        if (run_nxt && (state != ST_IDLE)) begin
            if (h_cnt == act_h[IDX_END]) begin
                v_nxt = (v_cnt == act_v[IDX_END]) ? '0 : v_cnt + 1'b1;
            end else begin
                h_nxt = h_cnt + 1'b1;
                v_nxt = v_cnt;
            end
        end
        // Strobes are decoded from next-cycle position so they register in step with it.
        hs_nxt   = run_nxt && (act_h_nxt[IDX_SYNC_START] <= h_nxt) && (h_nxt < act_h_nxt[IDX_SYNC_END]);
        vs_nxt   = run_nxt && (act_v_nxt[IDX_SYNC_START] <= v_nxt) && (v_nxt < act_v_nxt[IDX_SYNC_END]);
        hact_nxt = run_nxt && (act_h_nxt[IDX_ACT_START]  <= h_nxt) && (h_nxt < act_h_nxt[IDX_ACT_END]);
        vact_nxt = run_nxt && (act_v_nxt[IDX_ACT_START]  <= v_nxt) && (v_nxt < act_v_nxt[IDX_ACT_END]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
            hs    <= 1'b0;
            vs    <= 1'b0;
            de    <= 1'b0;
            sof   <= 1'b0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            hs    <= hs_nxt;
            vs    <= vs_nxt;
            de    <= hact_nxt && vact_nxt;
            sof   <= run_nxt && (h_nxt == '0) && (v_nxt == '0);
        end
    end

    assign busy        = (state != ST_IDLE);
    assign tHS_START   = act_h[IDX_SYNC_START];
    assign tHS_END     = act_h[IDX_SYNC_END];
    assign tHACT_START = act_h[IDX_ACT_START];
    assign tHACT_END   = act_h[IDX_ACT_END];
    assign tH_END      = act_h[IDX_END];
    assign tVS_START   = act_v[IDX_SYNC_START];
    assign tVS_END     = act_v[IDX_SYNC_END];
    assign tVACT_START = act_v[IDX_ACT_START];
    assign tVACT_END   = act_v[IDX_ACT_END];
    assign tV_END      = act_v[IDX_END];

endmodule

// File: tb/tb_tpg_timing_ctrl.sv
// Directed bench for tpg_timing_ctrl: hand-computed checkpoints plus a
// cycle model of the raster that is compared every clock.
module tb_tpg_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic [11:0] h_cnt, v_cnt;
    logic        hs, vs, de, sof, busy, pend, cfg_err;
    logic [30:0] dut_vec;

    int errors = 0;
    int checks = 0;

    int ms[10], mp[10], ma[10];
    int mh, mv, mst;
    bit mpend, merr, mapplied;

    tpg_timing_ctrl_if bus ();

    tpg_timing_ctrl #(.H_BITS(12), .V_BITS(12)) dut (
        .clk(clk), .rst_n(rst_n), .cfg(bus), .start(start), .stop(stop),
        .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
        .tHACT_END(tHACT_END), .tH_END(tH_END),
        .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
        .tVACT_END(tVACT_END), .tV_END(tV_END),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .hs(hs), .vs(vs), .de(de), .sof(sof),
        .busy(busy), .pend(pend), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    assign dut_vec = {h_cnt, v_cnt, hs, vs, de, sof, busy, pend, cfg_err};

    function automatic logic [30:0] model_vec();
        logic run, ehs, evs, ede;
        run = (mst != 0);
        ehs = run && (ma[0] <= mh) && (mh < ma[1]);
        evs = run && (ma[5] <= mv) && (mv < ma[6]);
        ede = run && (ma[2] <= mh) && (mh < ma[3]) && (ma[7] <= mv) && (mv < ma[8]);
        return {12'(mh), 12'(mv), ehs, evs, ede, run && (mh == 0) && (mv == 0), run, mpend, merr};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            ms[i] = 0; mp[i] = 0; ma[i] = 0;
        end
        mh = 0; mv = 0; mst = 0;
        mpend = 0; merr = 0; mapplied = 0;
    endtask

    // One clock: advance the model using the inputs currently driven, then sample at edge+1.
    task automatic tick();
        bit wrap, apply;
        int nst;
        wrap  = (mst != 0) && (mh == ma[4]) && (mv == ma[9]);
        apply = mpend && ((mst == 0) || wrap);
        nst   = mst;
        case (mst)
            0: if (start && !stop && mapplied) nst = 1;
            1: if (stop) nst = 2;
            2: if (start && !stop) nst = 1; else if (wrap) nst = 0;
            default: nst = 0;
        endcase
        if (nst == 0 || mst == 0) begin
            mh = 0; mv = 0;
        end else if (mh == ma[4]) begin
            mh = 0;
            mv = (mv == ma[9]) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        if (apply) begin
            ma = mp; mpend = 0; mapplied = 1;
        end
        mst = nst;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input int d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 4'(a);
        bus.cfg_wdata = 16'(d);
        tick();
        bus.cfg_we = 1'b0;
        if (a < 10) ms[a] = d;
    endtask

    task automatic commit(input bit ok);
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        if (ok) begin
            mp = ms; mpend = 1; merr = 0;
        end else begin
            merr = 1;
        end
    endtask

    // HS 1..3, HACT 2..8, VS 0..1, VACT 1..4, tV_END=4, caller picks tH_END.
    task automatic write_std(input int h_end);
        cfg_write(0, 1); cfg_write(1, 3); cfg_write(2, 2); cfg_write(3, 8); cfg_write(4, h_end);
        cfg_write(5, 0); cfg_write(6, 1); cfg_write(7, 1); cfg_write(8, 4); cfg_write(9, 4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = 4'd0; bus.cfg_wdata = 16'd0; bus.cfg_commit = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({h_cnt, v_cnt} !== 24'd0) begin
            errors++; $display("FAIL reset_counters: got %h want 0", {h_cnt, v_cnt});
        end
        checks++;
        if ({hs, vs, de, sof, busy, pend, cfg_err} !== 7'd0) begin
            errors++; $display("FAIL reset_flags: got %b want 0", {hs, vs, de, sof, busy, pend, cfg_err});
        end
        checks++;
        if ({tH_END, tV_END, tHS_END} !== 36'd0) begin
            errors++; $display("FAIL reset_timing: got %h want 0", {tH_END, tV_END, tHS_END});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, sof} !== 2'b00) begin
            errors++; $display("FAIL start_no_cfg: busy/sof got %b want 00", {busy, sof});
        end
        tick();
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL start_no_cfg_idle: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_basic_frame();
        int sof_cnt, sof2_idx, de_v0, de_v2, de_tot, hs_tot, vs_tot;
        sof_cnt = 0; sof2_idx = -1; de_v0 = 0; de_v2 = 0; de_tot = 0; hs_tot = 0; vs_tot = 0;
        write_std(9);
        commit(1'b1);
        checks++;
        if ({pend, cfg_err, tH_END} !== {1'b1, 1'b0, 12'd0}) begin
            errors++; $display("FAIL commit_idle: pend/err/tH_END got %b %b %0d want 1 0 0", pend, cfg_err, tH_END);
        end
        tick();
        checks++;
        if ({pend, tH_END, tV_END, tHACT_END, tVS_END} !== {1'b0, 12'd9, 12'd4, 12'd8, 12'd1}) begin
            errors++; $display("FAIL apply_idle: pend=%b tH_END=%0d tV_END=%0d tHACT_END=%0d tVS_END=%0d", pend, tH_END, tV_END, tHACT_END, tVS_END);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({h_cnt, v_cnt, sof, busy} !== {12'd0, 12'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL first_run_cycle: h=%0d v=%0d sof=%b busy=%b want 0 0 1 1", h_cnt, v_cnt, sof, busy);
        end
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL frame_cycle%0d: got %h want %h", i, dut_vec, model_vec());
            end
            if (sof) begin
                sof_cnt++;
                if (i > 0 && sof2_idx < 0) sof2_idx = i;
            end
            if (v_cnt == 12'd0) de_v0 += int'(de);
            if (v_cnt == 12'd2) de_v2 += int'(de);
            de_tot += int'(de);
            hs_tot += int'(hs);
            vs_tot += int'(vs);
            tick();
        end
        checks++;
        if (sof_cnt !== 2 || sof2_idx !== 50) begin
            errors++; $display("FAIL sof_period: count=%0d second_at=%0d want 2 50", sof_cnt, sof2_idx);
        end
        checks++;
        if (de_v2 !== 12 || de_v0 !== 0 || de_tot !== 36) begin
            errors++; $display("FAIL de_counts: line2=%0d line0=%0d total=%0d want 12 0 36", de_v2, de_v0, de_tot);
        end
        checks++;
        if (hs_tot !== 20 || vs_tot !== 20) begin
            errors++; $display("FAIL sync_counts: hs=%0d vs=%0d want 20 20", hs_tot, vs_tot);
        end
    endtask

    task automatic test_invalid_commit();
        cfg_write(0, 5);
        cfg_write(1, 3);
        commit(1'b0);
        checks++;
        if ({cfg_err, pend, tHS_START, tHS_END} !== {1'b1, 1'b0, 12'd1, 12'd3}) begin
            errors++; $display("FAIL invalid_commit: err=%b pend=%b hs_start=%0d hs_end=%0d want 1 0 1 3", cfg_err, pend, tHS_START, tHS_END);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL invalid_commit_state: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_midframe_update();
        cfg_write(0, 1);
        cfg_write(1, 3);
        cfg_write(4, 19);
        commit(1'b1);
        checks++;
        if ({cfg_err, pend, tH_END, h_cnt, v_cnt} !== {1'b0, 1'b1, 12'd9, 12'd7, 12'd0}) begin
            errors++; $display("FAIL midframe_commit: err=%b pend=%b tH_END=%0d h=%0d v=%0d want 0 1 9 7 0", cfg_err, pend, tH_END, h_cnt, v_cnt);
        end
        for (int i = 1; i <= 143; i++) begin
            tick();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL update_cycle%0d: got %h want %h", i, dut_vec, model_vec());
            end
            if (i == 3) begin
                checks++;
                if ({h_cnt, v_cnt, tH_END} !== {12'd0, 12'd1, 12'd9}) begin
                    errors++; $display("FAIL old_line_len: h=%0d v=%0d tH_END=%0d want 0 1 9", h_cnt, v_cnt, tH_END);
                end
            end
            if (i == 43) begin
                checks++;
                if ({h_cnt, v_cnt, sof, pend, tH_END} !== {12'd0, 12'd0, 1'b1, 1'b0, 12'd19}) begin
                    errors++; $display("FAIL wrap_apply: h=%0d v=%0d sof=%b pend=%b tH_END=%0d want 0 0 1 0 19", h_cnt, v_cnt, sof, pend, tH_END);
                end
            end
            if (i == 62) begin
                checks++;
                if ({h_cnt, v_cnt} !== {12'd19, 12'd0}) begin
                    errors++; $display("FAIL new_line_len: h=%0d v=%0d want 19 0", h_cnt, v_cnt);
                end
            end
        end
        checks++;
        if ({h_cnt, v_cnt, sof} !== {12'd0, 12'd0, 1'b1}) begin
            errors++; $display("FAIL long_frame: h=%0d v=%0d sof=%b want 0 0 1", h_cnt, v_cnt, sof);
        end
    endtask

    task automatic test_stop();
        cfg_write(4, 9);
        commit(1'b1);
        for (int i = 0; i < 98; i++) begin
            tick();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL revert_cycle%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if ({h_cnt, v_cnt, tH_END, pend} !== {12'd0, 12'd0, 12'd9, 1'b0}) begin
            errors++; $display("FAIL revert_apply: h=%0d v=%0d tH_END=%0d pend=%b want 0 0 9 0", h_cnt, v_cnt, tH_END, pend);
        end
        repeat (23) tick();
        checks++;
        if ({h_cnt, v_cnt} !== {12'd3, 12'd2}) begin
            errors++; $display("FAIL stop_point: h=%0d v=%0d want 3 2", h_cnt, v_cnt);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({h_cnt, v_cnt, busy} !== {12'd4, 12'd2, 1'b1}) begin
            errors++; $display("FAIL stopping: h=%0d v=%0d busy=%b want 4 2 1", h_cnt, v_cnt, busy);
        end
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL stopping_cycle%0d: got %h want %h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if ({h_cnt, v_cnt, busy} !== {12'd9, 12'd4, 1'b1}) begin
            errors++; $display("FAIL frame_tail: h=%0d v=%0d busy=%b want 9 4 1", h_cnt, v_cnt, busy);
        end
        tick();
        checks++;
        if ({h_cnt, v_cnt, busy, hs, vs, de, sof} !== {24'd0, 5'd0}) begin
            errors++; $display("FAIL stopped_idle: h=%0d v=%0d busy/hs/vs/de/sof=%b want all 0", h_cnt, v_cnt, {busy, hs, vs, de, sof});
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if ({busy, sof, h_cnt} !== {1'b0, 1'b0, 12'd0}) begin
            errors++; $display("FAIL start_stop_same: busy=%b sof=%b h=%0d want 0 0 0", busy, sof, h_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({h_cnt, hs, vs, busy} !== {12'd1, 1'b1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL pre_reset: h=%0d hs=%b vs=%b busy=%b want 1 1 1 1", h_cnt, hs, vs, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({h_cnt, v_cnt, hs, vs, de, sof, busy, pend, cfg_err} !== 31'd0) begin
            errors++; $display("FAIL async_reset: got %h want 0", dut_vec);
        end
        checks++;
        if ({tH_END, tHACT_END, tV_END} !== 36'd0) begin
            errors++; $display("FAIL async_reset_timing: got %h want 0", {tH_END, tHACT_END, tV_END});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, sof} !== 2'b00) begin
            errors++; $display("FAIL restart_no_cfg: busy/sof got %b want 00", {busy, sof});
        end
        write_std(9);
        commit(1'b1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({h_cnt, v_cnt, sof, busy} !== {24'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL restart_after_cfg: h=%0d v=%0d sof=%b busy=%b want 0 0 1 1", h_cnt, v_cnt, sof, busy);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL restart_state: got %h want %h", dut_vec, model_vec());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start_ignored();
        test_basic_frame();
        test_invalid_commit();
        test_midframe_update();
        test_stop();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
